// File: rtl/operand_read_stage.sv
// Operand read: splits the instruction, drives RF read addresses, resolves operands (r1 > r2 > rf) into the execute register; OPERAND_READ_STATS_EN adds event counters.
// One-cycle latency; stall holds the output register and drops in_ready, flush overrides stall and capture.
module operand_read_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           instruction,
    input  logic                  stall,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] rf_addr_1,
    output logic [ADDR_WIDTH-1:0] rf_addr_2,
    input  logic [DATA_WIDTH-1:0] rf_data_1,
    input  logic [DATA_WIDTH-1:0] rf_data_2,
    input  logic                  forward1_r1,
    input  logic                  forward2_r1,
    input  logic                  forward1_r2,
    input  logic                  forward2_r2,
    input  logic [DATA_WIDTH-1:0] r1_result,
    input  logic [DATA_WIDTH-1:0] r2_result,
    output logic                  out_valid,
    output logic [6:0]            out_opcode,
    output logic [ADDR_WIDTH-1:0] out_destination,
    output logic [DATA_WIDTH-1:0] out_operand_1,
    output logic [DATA_WIDTH-1:0] out_operand_2,
    output logic [ADDR_WIDTH-1:0] out_source_1,
    output logic [ADDR_WIDTH-1:0] out_source_2
`ifdef OPERAND_READ_STATS_EN
    ,
    output logic [15:0]           stall_count,
    output logic [15:0]           flush_count,
    output logic [15:0]           forward_count
`endif
);

    logic                  capture;
    logic                  any_forward;
    logic [DATA_WIDTH-1:0] operand_1;
    logic [DATA_WIDTH-1:0] operand_2;

    assign rf_addr_1   = ADDR_WIDTH'(instruction[5:3]);
    assign rf_addr_2   = ADDR_WIDTH'(instruction[2:0]);
    // Held high through reset so upstream never sees a spurious stall.
    assign in_ready    = rst | ~stall;
    assign capture     = in_valid & ~stall & ~flush;
    assign any_forward = forward1_r1 | forward1_r2 | forward2_r1 | forward2_r2;

    // r1 is the younger result, so it wins over r2.
    always_comb begin
        operand_1 = rf_data_1;
        if (forward1_r1)      operand_1 = r1_result;
        else if (forward1_r2) operand_1 = r2_result;

        operand_2 = rf_data_2;
        if (forward2_r1)      operand_2 = r1_result;
        else if (forward2_r2) operand_2 = r2_result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid       <= 1'b0;
            out_opcode      <= '0;
            out_destination <= '0;
            out_operand_1   <= '0;
            out_operand_2   <= '0;
            out_source_1    <= '0;
            out_source_2    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_opcode      <= instruction[15:9];
                out_destination <= ADDR_WIDTH'(instruction[8:6]);
                out_operand_1   <= operand_1;
                out_operand_2   <= operand_2;
                out_source_1    <= ADDR_WIDTH'(instruction[5:3]);
                out_source_2    <= ADDR_WIDTH'(instruction[2:0]);
            end
        end
    end

`ifdef OPERAND_READ_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count   <= '0;
            flush_count   <= '0;
            forward_count <= '0;
        end else begin
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
            if (flush && flush_count != 16'hFFFF)
                flush_count <= flush_count + 16'd1;
            if (capture && any_forward && forward_count != 16'hFFFF)
                forward_count <= forward_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_read_stage.sv
// Bench for operand_read_stage: directed cases plus randomized traffic against a cycle-level model.
module tb_operand_read_stage;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int VW = 1 + 7 + 3 * AW + 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, stall, flush;
    logic [15:0]   instruction;
    logic [AW-1:0] rf_addr_1, rf_addr_2;
    logic [DW-1:0] rf_data_1, rf_data_2, r1_result, r2_result;
    logic          forward1_r1, forward2_r1, forward1_r2, forward2_r2;
    logic          out_valid;
    logic [6:0]    out_opcode;
    logic [AW-1:0] out_destination, out_source_1, out_source_2;
    logic [DW-1:0] out_operand_1, out_operand_2;
`ifdef OPERAND_READ_STATS_EN
    logic [15:0]   stall_count, flush_count, forward_count;
`endif

    always #5 clk = ~clk;

    logic [DW-1:0] regs [8];
    assign rf_data_1 = regs[rf_addr_1];
    assign rf_data_2 = regs[rf_addr_2];

    operand_read_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .stall(stall), .flush(flush),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
        .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .forward1_r1(forward1_r1), .forward2_r1(forward2_r1),
        .forward1_r2(forward1_r2), .forward2_r2(forward2_r2),
        .r1_result(r1_result), .r2_result(r2_result),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_destination(out_destination),
        .out_operand_1(out_operand_1), .out_operand_2(out_operand_2),
        .out_source_1(out_source_1), .out_source_2(out_source_2)
`ifdef OPERAND_READ_STATS_EN
        , .stall_count(stall_count), .flush_count(flush_count), .forward_count(forward_count)
`endif
    );

    // Reference state: what the execute-side register should hold.
    logic          m_valid;
    logic [6:0]    m_op;
    logic [2:0]    m_dst, m_s1, m_s2;
    logic [DW-1:0] m_o1, m_o2;
    logic [15:0]   m_sc, m_fc, m_wc;
    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] pick(input logic f_r1, input logic f_r2,
                                           input logic [DW-1:0] v_r1, input logic [DW-1:0] v_r2,
                                           input logic [DW-1:0] v_rf);
        if (f_r1) return v_r1;
        if (f_r2) return v_r2;
        return v_rf;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {out_valid, out_opcode, out_destination, out_source_1, out_source_2,
                out_operand_1, out_operand_2};
    endfunction

    function automatic logic [VW-1:0] mdl_vec();
        return {m_valid, m_op, m_dst, m_s1, m_s2, m_o1, m_o2};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_op = 0; m_dst = 0; m_s1 = 0; m_s2 = 0; m_o1 = 0; m_o2 = 0;
        m_sc = 0; m_fc = 0; m_wc = 0;
    endtask

    // Advance one clock and apply the stage rules to the inputs seen at that edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (stall && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
            if (flush && m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
            if (flush) begin
                m_valid = 0;
            end else if (!stall) begin
                if (in_valid) begin
                    m_valid = 1;
                    m_op  = instruction[15:9];
                    m_dst = instruction[8:6];
                    m_s1  = instruction[5:3];
                    m_s2  = instruction[2:0];
                    m_o1  = pick(forward1_r1, forward1_r2, r1_result, r2_result, regs[instruction[5:3]]);
                    m_o2  = pick(forward2_r1, forward2_r2, r1_result, r2_result, regs[instruction[2:0]]);
                    if ((forward1_r1 | forward1_r2 | forward2_r1 | forward2_r2) && m_wc != 16'hFFFF)
                        m_wc = m_wc + 16'd1;
                end else begin
                    m_valid = 0;
                end
            end
        end
        #1;
    endtask

    // fw = {forward1_r1, forward1_r2, forward2_r1, forward2_r2}
    task automatic drive(input logic v, input logic [15:0] ins, input logic st, input logic fl,
                         input logic [3:0] fw);
        @(negedge clk);
        in_valid = v; instruction = ins; stall = st; flush = fl;
        {forward1_r1, forward1_r2, forward2_r1, forward2_r2} = fw;
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 0; stall = 0; flush = 0; instruction = 16'h0000;
        {forward1_r1, forward1_r2, forward2_r1, forward2_r2} = 4'b0;
        r1_result = 0; r2_result = 0;
        for (int i = 0; i < 8; i++) regs[i] = $urandom;
        model_reset();
        #22;
        checks++;
        if (dut_vec() !== {VW{1'b0}}) begin
            errors++; $display("FAIL reset_outputs: got %h expected all zero", dut_vec());
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        instruction = 16'b0000000_000_101_110;
        #1;
        checks++;
        if ({rf_addr_1, rf_addr_2} !== {3'd5, 3'd6}) begin
            errors++; $display("FAIL rf_addr_comb: got %0d/%0d expected 5/6", rf_addr_1, rf_addr_2);
        end
`ifdef OPERAND_READ_STATS_EN
        checks++;
        if ({stall_count, flush_count, forward_count} !== 48'd0) begin
            errors++; $display("FAIL reset_counters: got %h expected 0", {stall_count, flush_count, forward_count});
        end
`endif
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        regs[1] = 5; regs[2] = 7;
        drive(1, {7'h01, 3'd3, 3'd1, 3'd2}, 0, 0, 4'b0000);
        step();
        checks++;
        if ({out_valid, out_operand_1, out_operand_2} !== {1'b1, 32'd5, 32'd7}) begin
            errors++; $display("FAIL basic_add: got v=%b %0d %0d expected v=1 5 7", out_valid, out_operand_1, out_operand_2);
        end
        checks++;
        if ({out_opcode, out_destination} !== {7'h01, 3'd3}) begin
            errors++; $display("FAIL basic_fields: got op=%h dst=%0d expected op=01 dst=3", out_opcode, out_destination);
        end
    endtask

    task automatic test_forward();
        r1_result = 32'h10; r2_result = 32'h20;
        drive(1, {7'h02, 3'd4, 3'd3, 3'd5}, 0, 0, 4'b1001);
        step();
        checks++;
        if ({out_operand_1, out_operand_2} !== {32'h10, 32'h20}) begin
            errors++; $display("FAIL forward_mix: got %h %h expected 10 20", out_operand_1, out_operand_2);
        end
        r1_result = 32'd1; r2_result = 32'd2;
        drive(1, {7'h03, 3'd1, 3'd6, 3'd7}, 0, 0, 4'b1111);
        step();
        checks++;
        if ({out_operand_1, out_operand_2} !== {32'd1, 32'd1}) begin
            errors++; $display("FAIL forward_all: got %h %h expected 1 1", out_operand_1, out_operand_2);
        end
    endtask

    task automatic test_stall();
        drive(1, {7'h11, 3'd2, 3'd1, 3'd2}, 0, 0, 4'b0000);
        step();
        for (int i = 0; i < 3; i++) begin
            r1_result = $urandom; r2_result = $urandom;
            drive(1, {7'h22, 3'd5, 3'd3, 3'd4}, 1, 0, 4'($urandom));
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
            end
            step();
            checks++;
            if (dut_vec() !== mdl_vec() || out_opcode !== 7'h11) begin
                errors++; $display("FAIL stall_hold: got %h expected %h", dut_vec(), mdl_vec());
            end
        end
        drive(1, {7'h33, 3'd6, 3'd5, 3'd0}, 0, 0, 4'b0000);
        step();
        checks++;
        if (dut_vec() !== mdl_vec() || out_opcode !== 7'h33) begin
            errors++; $display("FAIL stall_release: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_flush();
        drive(1, {7'h44, 3'd1, 3'd1, 3'd1}, 0, 0, 4'b0000);
        step();
        drive(1, {7'h55, 3'd2, 3'd2, 3'd2}, 1, 1, 4'b0000);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_stall_valid: got %b expected 0", out_valid);
        end
        drive(0, {7'h55, 3'd2, 3'd2, 3'd2}, 0, 0, 4'b0000);
        step();
        checks++;
        if (out_valid !== 1'b0 || out_opcode === 7'h55 || dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL flush_dropped: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_bubble();
        drive(1, {7'h66, 3'd7, 3'd4, 3'd3}, 0, 0, 4'b0000);
        step();
        drive(0, {7'h77, 3'd0, 3'd0, 3'd0}, 0, 0, 4'b0000);
        step();
        checks++;
        if (out_valid !== 1'b0 || out_opcode !== 7'h66 || dut_vec() !== mdl_vec()) begin
            errors++; $display("FAIL bubble: got %h expected %h", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            regs[i] = $urandom;
            r1_result = $urandom; r2_result = $urandom;
            drive(1, 16'($urandom), 0, 0, 4'($urandom));
            step();
            checks++;
            if (out_valid !== 1'b1 || dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(1, {7'h12, 3'd1, 3'd2, 3'd3}, 0, 0, 4'b0000);
        step();
        drive(1, {7'h13, 3'd1, 3'd2, 3'd3}, 1, 0, 4'b0000);
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stall: got %b expected 0", out_valid);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            regs[$urandom_range(0, 7)] = $urandom;
            r1_result = $urandom; r2_result = $urandom;
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, 4'($urandom));
            #1;
            checks++;
            if ({rf_addr_1, rf_addr_2, in_ready} !== {instruction[5:3], instruction[2:0], ~stall}) begin
                errors++; $display("FAIL random_comb[%0d]: got %0d %0d %b", i, rf_addr_1, rf_addr_2, in_ready);
            end
            step();
            checks++;
            if (dut_vec() !== mdl_vec()) begin
                errors++; $display("FAIL random_out[%0d]: got %h expected %h", i, dut_vec(), mdl_vec());
            end
`ifdef OPERAND_READ_STATS_EN
            checks++;
            if ({stall_count, flush_count, forward_count} !== {m_sc, m_fc, m_wc}) begin
                errors++; $display("FAIL random_counters[%0d]: got %h expected %h", i,
                                   {stall_count, flush_count, forward_count}, {m_sc, m_fc, m_wc});
            end
`endif
        end
    endtask

`ifdef OPERAND_READ_STATS_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1; model_reset();
        @(negedge clk);
        rst = 0;
        drive(0, 16'h0, 1, 0, 4'b0000); step();
        drive(0, 16'h0, 1, 0, 4'b0000); step();
        drive(0, 16'h0, 0, 1, 4'b0000); step();
        drive(1, 16'h1234, 0, 0, 4'b0000); step();
        drive(1, 16'h5678, 0, 0, 4'b0100); step();
        drive(1, 16'h9abc, 0, 0, 4'b0000); step();
        drive(0, 16'h0, 0, 0, 4'b0000); step();
        checks++;
        if ({stall_count, flush_count, forward_count} !== {16'd2, 16'd1, 16'd1}) begin
            errors++; $display("FAIL stats_counts: got %0d %0d %0d expected 2 1 1", stall_count, flush_count, forward_count);
        end
        drive(0, 16'h0, 1, 0, 4'b0000);
        repeat (70000) @(posedge clk);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++; $display("FAIL stats_saturate: got %h expected ffff", stall_count);
        end
        @(negedge clk);
        stall = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_forward();
        test_stall();
        test_flush();
        test_bubble();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
`ifdef OPERAND_READ_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/operand_read_stage.md
# operand_read_stage

Pipeline stage between instruction fetch and execute of the pipelined processor. It splits the fetched 16-bit instruction into opcode and register fields and drives register-file read addresses. It builds both source operands, taking register-file data or forwarded results as selected by the dependency-control flags. It then registers the operands for the execute stage, with stall, flush and bubble handling.

## Interface
- `DATA_WIDTH`, 32: operand and result width.
- `ADDR_WIDTH`, 3: register address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetched instruction valid.
- `in_ready` out 1: stage accepts an instruction this cycle.
- `instruction` in 16: fields are opcode [15:9], destination [8:6], source_1 [5:3], source_2 [2:0].
- `stall` in 1: execute stage cannot accept; hold the output register.
- `flush` in 1: branch taken; discard the held and incoming instruction.
- `rf_addr_1`, `rf_addr_2` out `ADDR_WIDTH`: combinational register-file read addresses.
- `rf_data_1`, `rf_data_2` in `DATA_WIDTH`: register-file read data, same cycle.
- `forward1_r1`, `forward2_r1`, `forward1_r2`, `forward2_r2` in 1: dependency-control flags.
- `r1_result`, `r2_result` in `DATA_WIDTH`: results from the execute stage (r1) and the writeback stage (r2).
- `out_valid` out 1: output register holds a live instruction.
- `out_opcode` out 7, `out_destination` out `ADDR_WIDTH`: registered fields.
- `out_operand_1`, `out_operand_2` out `DATA_WIDTH`: registered resolved operands.
- `out_source_1`, `out_source_2` out `ADDR_WIDTH`: registered source addresses, passed downstream to dependency control.

## Operation
- `rf_addr_1` = `instruction[5:3]` and `rf_addr_2` = `instruction[2:0]`, combinational regardless of `in_valid`.
- Operand 1 mux priority:
  - `forward1_r1` selects `r1_result`.
  - else `forward1_r2` selects `r2_result`.
  - else `rf_data_1`.
- Operand 2 uses the same priority with `forward2_r1`, `forward2_r2` and `rf_data_2`. r1 wins when both flags are set, because r1 holds the newer value.
- `in_ready` = `~stall`.
- Capture occurs when `in_valid & in_ready & ~flush`. All out_* fields load and `out_valid` goes to 1.
- If `in_ready` is high with no capture (`in_valid` = 0), the stage inserts a bubble: `out_valid` goes to 0 and the data fields keep their old values.
- While `stall` is high and `flush` is low, every output register holds its value. Forward flags and results are ignored, and the instruction is not re-sampled.
- `flush` has priority over `stall` and capture. The next cycle `out_valid` = 0, and the incoming instruction is dropped with no error flag.
- Operand widths pass through unchanged; the stage does no arithmetic.

## Timing
- Latency is 1 cycle from capture to the out_* fields.
- Forward flags and results are sampled in the same cycle as the instruction they refer to, i.e. the cycle in which `rf_addr_*` is presented.
- Reset values: `out_valid` = 0, every other out_* register = 0.
- `in_ready` is combinational and equals 1 during reset.
- Reset mid-stall clears `out_valid` immediately, without waiting for a clock edge.
- `stall` and `flush` in the same cycle: the flush is applied, so `out_valid` = 0 on the next edge.
- Back-to-back valid instructions with `stall` low give one output per cycle with no bubbles.

## Configuration
- Macro `OPERAND_READ_STATS_EN`.
- When defined, the block adds:
  - 16-bit outputs `stall_count`, `flush_count` and `forward_count`, reset to 0 and saturating at 16'hFFFF.
  - `stall_count` increments each cycle with `stall` high.
  - `flush_count` increments each cycle with `flush` high.
  - `forward_count` increments on each capture in which any forward flag is high: +1 per instruction, not per operand.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- After reset, ADD with rf_data 5 and 7, no forward flags -> next cycle `out_valid` = 1, operands 5 and 7, opcode and destination match the instruction.
- `forward1_r1` = 1 with `r1_result` = 0x10, and `forward2_r2` = 1 with `r2_result` = 0x20 -> operands 0x10 and 0x20.
- All four forward flags set, `r1_result` = 1, `r2_result` = 2 -> both operands = 1.
- Hold `stall` for 3 cycles while `in_valid` = 1 -> `in_ready` = 0 and outputs stay frozen. The instruction presented after release is captured 1 cycle later.
- `flush` together with `stall` and `in_valid` -> next cycle `out_valid` = 0 and the dropped instruction never appears.
- With `OPERAND_READ_STATS_EN`: 2 stall cycles, 1 flush, 3 captures of which 1 forwarded -> counts 2, 1, 1. Forcing `stall` for 70000 cycles -> `stall_count` = 0xFFFF.
